// File: rtl/mult_div_unit.sv
// Iterative signed multiply / restoring divide feeding the HI/LO pair.
// Optional MULTU/DIVU support: define MULTDIV_UNSIGNED_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_write,
    output logic             lo_write
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic               op_q, neg_res_q, neg_rem_q, dz_q;
    logic               busy_q, done_q, div_zero_q;
    logic               hi_write_q, lo_write_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

`ifdef MULTDIV_UNSIGNED_EN
    assign sgn_op = ~is_unsigned;
`else
    logic unused_is_unsigned;
    assign unused_is_unsigned = is_unsigned;
    assign sgn_op = 1'b1;
`endif

    assign a_neg = sgn_op & a[WIDTH-1];
    assign b_neg = sgn_op & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply: shift-add; divide: restoring, acc = {remainder, quotient}
    always_comb begin
        acc_d = acc_q;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
        if (!op_q) begin
            if (acc_q[0])
                acc_d = {sum, acc_q[WIDTH-1:1]};
            else
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_s = neg_res_q ? -acc_q : acc_q;
        quo_s  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            op_q       <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        opb_q     <= b_mag;
                        acc_q     <= {{WIDTH{1'b0}}, a_mag};
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= CW'(WIDTH);
                        busy_q    <= 1'b1;
                        if (op && b == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            dz_q    <= 1'b0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_q <= FINISH;
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (dz_q) begin
                        div_zero_q <= 1'b1;
                        hi_q       <= '0;
                        lo_q       <= '0;
                    end else begin
                        hi_write_q <= 1'b1;
                        lo_write_q <= 1'b1;
                        hi_q <= op_q ? rem_s : prod_s[2*WIDTH-1:WIDTH];
                        lo_q <= op_q ? quo_s : prod_s[WIDTH-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign hi_write = hi_write_q;
    assign lo_write = lo_write_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Expected MULTU result depends on MULTDIV_UNSIGNED_EN.
module tb_mult_div_unit;

    logic        clk, reset, start, op, is_unsigned;
    logic [31:0] a, b;
    logic        busy, done, div_zero, hi_write, lo_write;
    logic [31:0] hi_out, lo_out;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .is_unsigned(is_unsigned), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out),
        .hi_write(hi_write), .lo_write(lo_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request, let edge E0 accept it, then scramble operands.
    task automatic go(input logic o, input logic u,
                      input logic [31:0] x, input logic [31:0] y);
        op = o; is_unsigned = u; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy, done, div_zero, hi_write, lo_write} !== 5'b0 ||
            hi_out !== 32'h0 || lo_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b %h %h want 0",
                     {busy, done, div_zero, hi_write, lo_write},
                     hi_out, lo_out);
        end
    endtask

    task automatic test_mult;
        go(1'b0, 1'b0, 32'd7, 32'hFFFFFFFD);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_busy_e0: got busy=%b done=%b want 1 0",
                     busy, done);
        end
        repeat (32) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_busy_e32: got busy=%b done=%b want 1 0",
                     busy, done);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || hi_write !== 1'b1 ||
            lo_write !== 1'b1 || div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_flags: got d=%b b=%b hw=%b lw=%b dz=%b want 1 0 1 1 0",
                     done, busy, hi_write, lo_write, div_zero);
        end
        n_cmp++;
        if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
            n_bad++;
            $display("FAIL mult_result: got %h_%h want ffffffff_ffffffeb",
                     hi_out, lo_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || hi_write !== 1'b0 || lo_write !== 1'b0 ||
            hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
            n_bad++;
            $display("FAIL mult_pulse_hold: got d=%b hw=%b lw=%b %h_%h want 0 0 0 ffffffff_ffffffeb",
                     done, hi_write, lo_write, hi_out, lo_out);
        end
    endtask

    task automatic test_div;
        go(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
        repeat (32) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL div_early_done: got %b want 0", done);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b1 || div_zero !== 1'b0 ||
            lo_out !== 32'hFFFFFFFD || hi_out !== 32'hFFFFFFFF) begin
            n_bad++;
            $display("FAIL div_neg: got d=%b dz=%b q=%h r=%h want 1 0 fffffffd ffffffff",
                     done, div_zero, lo_out, hi_out);
        end
    endtask

    task automatic test_div_zero;
        go(1'b1, 1'b0, 32'd5, 32'd0);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_e0: got busy=%b done=%b want 1 0", busy, done);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0 ||
            hi_write !== 1'b0 || lo_write !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_flags: got d=%b dz=%b b=%b hw=%b lw=%b want 1 1 0 0 0",
                     done, div_zero, busy, hi_write, lo_write);
        end
        n_cmp++;
        if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
            n_bad++;
            $display("FAIL dz_data: got %h_%h want 0_0", hi_out, lo_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_pulse: got d=%b dz=%b want 0 0", done, div_zero);
        end
    endtask

    task automatic test_div_overflow;
        go(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        repeat (33) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || hi_write !== 1'b1 || lo_write !== 1'b1 ||
            div_zero !== 1'b0 || lo_out !== 32'h80000000 ||
            hi_out !== 32'h0) begin
            n_bad++;
            $display("FAIL div_ovf: got d=%b hw=%b lw=%b dz=%b q=%h r=%h want 1 1 1 0 80000000 0",
                     done, hi_write, lo_write, div_zero, lo_out, hi_out);
        end
    endtask

    task automatic test_busy_ignore;
        logic early;
        early = 1'b0;
        go(1'b0, 1'b0, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        op = 1'b1; a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            if (done === 1'b1 || busy !== 1'b1) early = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (early || done !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_busy: got early=%b done=%b busy=%b want 0 0 1",
                     early, done, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b1 || hi_out !== 32'h0 || lo_out !== 32'd12) begin
            n_bad++;
            $display("FAIL ignore_result: got d=%b %h_%h want 1 0_c",
                     done, hi_out, lo_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_no_queue: got busy=%b done=%b want 0 0",
                     busy, done);
        end
    endtask

    task automatic test_back_to_back;
        go(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (33) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || lo_out !== 32'd14 || hi_out !== 32'd2) begin
            n_bad++;
            $display("FAIL b2b_first: got d=%b q=%h r=%h want 1 e 2",
                     done, lo_out, hi_out);
        end
        go(1'b1, 1'b0, 32'hFFFFFF9C, 32'd7);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1 0",
                     busy, done);
        end
        repeat (33) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || lo_out !== 32'hFFFFFFF2 ||
            hi_out !== 32'hFFFFFFFE) begin
            n_bad++;
            $display("FAIL b2b_second: got d=%b q=%h r=%h want 1 fffffff2 fffffffe",
                     done, lo_out, hi_out);
        end
    endtask

    task automatic test_reset_abort;
        logic pulse;
        pulse = 1'b0;
        go(1'b0, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, div_zero, hi_write, lo_write} !== 5'b0 ||
            hi_out !== 32'h0 || lo_out !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %b %h %h want 0",
                     {busy, done, div_zero, hi_write, lo_write},
                     hi_out, lo_out);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || hi_write === 1'b1 || lo_write === 1'b1 ||
                busy === 1'b1)
                pulse = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulse) begin
            n_bad++;
            $display("FAIL abort_no_pulse: got pulse=%b want 0", pulse);
        end
        go(1'b0, 1'b0, 32'd3, 32'd4);
        repeat (33) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || hi_out !== 32'h0 || lo_out !== 32'd12) begin
            n_bad++;
            $display("FAIL abort_rerun: got d=%b %h_%h want 1 0_c",
                     done, hi_out, lo_out);
        end
    endtask

    task automatic test_unsigned;
        logic [31:0] exp_hi;
`ifdef MULTDIV_UNSIGNED_EN
        exp_hi = 32'h00000001;
`else
        exp_hi = 32'hFFFFFFFF;
`endif
        go(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
        repeat (33) @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || hi_out !== exp_hi ||
            lo_out !== 32'hFFFFFFFE) begin
            n_bad++;
            $display("FAIL multu: got d=%b %h_%h want 1 %h_fffffffe",
                     done, hi_out, lo_out, exp_hi);
        end
        is_unsigned = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; is_unsigned = 1'b0;
        a = '0; b = '0;
        #2;
        test_reset;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        test_mult;
        test_div;
        test_div_zero;
        test_div_overflow;
        test_busy_ignore;
        test_back_to_back;
        test_reset_abort;
        test_unsigned;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
